// File: rtl/spi_ring_txn_sequencer.sv
// SPI-side ring-buffer transaction sequencer for the MIL-STD/SPI bridge.
// A decoded SEND_DATA or RECEIVE_DATA frame opens a transaction on the matching
// buffer. The transaction is committed when the frame closes with the announced
// word count. Errors, aborts, count overflow, count mismatch and inactivity
// timeouts roll it back.
module spi_ring_txn_sequencer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             frameStart,
  input  logic             frameEnd,
  input  logic             frameError,
  input  logic [1:0]       addrHit,
  input  logic             cmdSend,
  input  logic             cmdRecv,
  input  logic [CNT_W-1:0] expectedWords,
  input  logic             wordStrobe,
  output logic [1:0]       smOpen,
  output logic [1:0]       smCommit,
  output logic [1:0]       smRollback,
  output logic [1:0]       msOpen,
  output logic [1:0]       msCommit,
  output logic [1:0]       msRollback,
  output logic             busy,
  output logic [1:0]       lastStatus,
  output logic [7:0]       errCount
);

  typedef enum logic [2:0] {IDLE, OPEN, ACTIVE, COMMIT, ROLLBACK} seqState;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  seqState          state;
  logic             chan;        // latched channel index
  logic             dirSm;       // 1: SPI->MIL (send), 0: MIL->SPI (receive)
  logic [CNT_W-1:0] expected;
  logic [CNT_W-1:0] wordCnt;
  logic [15:0]      toCnt;
  logic             rbTimeout;   // rollback reason held for the ROLLBACK cycle

  logic             cmdValid;
  logic             overflow;
  logic             countMatch;
  logic             timeoutHit;
  logic             closeNow;
  logic             closeCommit;
  logic             closeTimeout;
  logic [15:0]      toNext;
  logic [CNT_W:0]   wordSum;

  // Error counter increments but holds at its maximum value.
  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Converts a channel index to its one-hot control bit.
  function automatic logic [1:0] chanMask(input logic c);
    return c ? 2'b10 : 2'b01;
  endfunction

  // Decide whether an open transaction ends this cycle, and how.
  always_comb begin
    cmdValid     = ((addrHit == 2'b01) || (addrHit == 2'b10)) && (cmdSend != cmdRecv);
    toNext       = toCnt + 16'd1;
    wordSum      = {1'b0, wordCnt} + {{CNT_W{1'b0}}, wordStrobe};
    overflow     = wordStrobe && (&wordCnt);
    countMatch   = (wordSum == {1'b0, expected});
    timeoutHit   = !wordStrobe && (toNext == TIMEOUT_LIM);
    closeNow     = 1'b0;
    closeCommit  = 1'b0;
    closeTimeout = 1'b0;
    // A frameStart while busy aborts the transaction and the new frame is dropped.
    if (frameError || frameStart || overflow) begin
      closeNow = 1'b1;
    end else if (frameEnd) begin
      closeNow    = 1'b1;
      closeCommit = countMatch;
    end else if (timeoutHit) begin
      closeNow     = 1'b1;
      closeTimeout = 1'b1;
    end
  end

  // Transaction FSM with registered control pulses and status.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      chan       <= 1'b0;
      dirSm      <= 1'b0;
      expected   <= '0;
      wordCnt    <= '0;
      toCnt      <= '0;
      rbTimeout  <= 1'b0;
      smOpen     <= 2'b00;
      smCommit   <= 2'b00;
      smRollback <= 2'b00;
      msOpen     <= 2'b00;
      msCommit   <= 2'b00;
      msRollback <= 2'b00;
      busy       <= 1'b0;
      lastStatus <= 2'b00;
      errCount   <= 8'd0;
    end else begin
      smOpen     <= 2'b00;
      smCommit   <= 2'b00;
      smRollback <= 2'b00;
      msOpen     <= 2'b00;
      msCommit   <= 2'b00;
      msRollback <= 2'b00;
      case (state)
        IDLE: begin
          if (frameStart && cmdValid) begin
            chan     <= addrHit[1];
            dirSm    <= cmdSend;
            expected <= expectedWords;
            wordCnt  <= '0;
            toCnt    <= '0;
            busy     <= 1'b1;
            state    <= OPEN;
            if (cmdSend) smOpen <= addrHit;
            else         msOpen <= addrHit;
          end
        end
        OPEN, ACTIVE: begin
          wordCnt <= wordSum[CNT_W-1:0];
          toCnt   <= wordStrobe ? 16'd0 : toNext;
          if (closeNow && closeCommit) begin
            state <= COMMIT;
            if (dirSm) smCommit <= chanMask(chan);
            else       msCommit <= chanMask(chan);
          end else if (closeNow) begin
            state     <= ROLLBACK;
            rbTimeout <= closeTimeout;
            if (dirSm) smRollback <= chanMask(chan);
            else       msRollback <= chanMask(chan);
          end else begin
            state <= ACTIVE;
          end
        end
        COMMIT: begin
          lastStatus <= 2'b01;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        ROLLBACK: begin
          lastStatus <= rbTimeout ? 2'b11 : 2'b10;
          errCount   <= satInc(errCount);
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ring_txn_sequencer.sv
// Self-checking bench for spi_ring_txn_sequencer: directed scenarios with
// literal expectations plus randomized traffic against a transaction model.
module tb_spi_ring_txn_sequencer;

  localparam int TMO = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          nRst = 1'b0;
  logic          frameStart = 1'b0;
  logic          frameEnd = 1'b0;
  logic          frameError = 1'b0;
  logic [1:0]    addrHit = 2'b00;
  logic          cmdSend = 1'b0;
  logic          cmdRecv = 1'b0;
  logic [CW-1:0] expectedWords = '0;
  logic          wordStrobe = 1'b0;
  logic [1:0]    smOpen, smCommit, smRollback, msOpen, msCommit, msRollback;
  logic          busy;
  logic [1:0]    lastStatus;
  logic [7:0]    errCount;

  int checks = 0;
  int failures = 0;

  // Model state: one transaction record and the outputs it implies.
  bit          mInTxn = 0;
  bit          mClosing = 0;
  int          mDirMs = 0;
  int          mChan = 0;
  int          mExp = 0;
  int          mWords = 0;
  int          mSilence = 0;
  int          mCloseCode = 0;
  logic [11:0] ePulse = '0;
  logic        eBusy = 1'b0;
  logic [1:0]  eStatus = 2'b00;
  int          eErr = 0;

  always #5 clk = ~clk;

  spi_ring_txn_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .nRst(nRst), .frameStart(frameStart), .frameEnd(frameEnd),
    .frameError(frameError), .addrHit(addrHit), .cmdSend(cmdSend), .cmdRecv(cmdRecv),
    .expectedWords(expectedWords), .wordStrobe(wordStrobe),
    .smOpen(smOpen), .smCommit(smCommit), .smRollback(smRollback),
    .msOpen(msOpen), .msCommit(msCommit), .msRollback(msRollback),
    .busy(busy), .lastStatus(lastStatus), .errCount(errCount)
  );

  function automatic logic [11:0] pulses();
    return {msRollback, msCommit, msOpen, smRollback, smCommit, smOpen};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, wanted %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Transaction-level reference: what each clock edge must produce.
  task automatic modelStep();
    int code;
    if (!nRst) begin
      mInTxn = 0; mClosing = 0; mWords = 0; mSilence = 0;
      ePulse = '0; eBusy = 1'b0; eStatus = 2'b00; eErr = 0;
      return;
    end
    ePulse = '0;
    if (mClosing) begin
      eStatus = 2'(mCloseCode);
      if (mCloseCode != 1) eErr = (eErr < 255) ? eErr + 1 : 255;
      mClosing = 0;
      eBusy = 1'b0;
    end else if (mInTxn) begin
      code = 0;
      if (frameError || frameStart) code = 2;
      else if (wordStrobe && mWords == (1 << CW) - 1) code = 2;
      else if (frameEnd) code = (mWords + int'(wordStrobe) == mExp) ? 1 : 2;
      else if (!wordStrobe && mSilence + 1 == TMO) code = 3;
      mWords = mWords + int'(wordStrobe);
      mSilence = wordStrobe ? 0 : mSilence + 1;
      if (code != 0) begin
        mInTxn = 0;
        mClosing = 1;
        mCloseCode = code;
        ePulse[mDirMs * 6 + ((code == 1) ? 2 : 4) + mChan] = 1'b1;
      end
    end else if (frameStart && $countones(addrHit) == 1 && (cmdSend ^ cmdRecv)) begin
      mInTxn = 1;
      mDirMs = cmdRecv ? 1 : 0;
      mChan = addrHit[1] ? 1 : 0;
      mExp = int'(expectedWords);
      mWords = 0;
      mSilence = 0;
      ePulse[mDirMs * 6 + mChan] = 1'b1;
      eBusy = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge nRst);
    modelStep();
  end

  // Every cycle: compare all outputs to the model on the falling edge.
  initial forever begin
    @(negedge clk);
    check("pulses", 32'(pulses()), 32'(ePulse));
    check("busy", 32'(busy), 32'(eBusy));
    check("lastStatus", 32'(lastStatus), 32'(eStatus));
    check("errCount", 32'(errCount), 32'(eErr));
    check("onePulseMax", 32'($countones(pulses()) <= 1), 32'd1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    frameStart = 1'b0; frameEnd = 1'b0; frameError = 1'b0; wordStrobe = 1'b0;
  endtask

  task automatic startTxn(input logic [1:0] hit, input logic snd, input logic rcv, input int exp);
    frameStart = 1'b1; addrHit = hit; cmdSend = snd; cmdRecv = rcv;
    expectedWords = CW'(exp);
    step();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_pulses", 32'(pulses()), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_status", 32'(lastStatus), 32'd0);
    check("rst_err", 32'(errCount), 32'd0);
    nRst = 1'b1;
    step();

    // SEND to addr0, 3 words, clean close.
    startTxn(2'b01, 1'b1, 1'b0, 3);
    check("t1_smOpen", 32'(smOpen), 32'h1);
    check("t1_busy", 32'(busy), 32'd1);
    repeat (3) begin wordStrobe = 1'b1; step(); end
    frameEnd = 1'b1; step();
    check("t1_smCommit", 32'(smCommit), 32'h1);
    step();
    check("t1_status", 32'(lastStatus), 32'h1);
    check("t1_err", 32'(errCount), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // RECEIVE from addr1, short by one word.
    startTxn(2'b10, 1'b0, 1'b1, 2);
    check("t2_msOpen", 32'(msOpen), 32'h2);
    wordStrobe = 1'b1; step();
    frameEnd = 1'b1; step();
    check("t2_msRollback", 32'(msRollback), 32'h2);
    step();
    check("t2_status", 32'(lastStatus), 32'h2);
    check("t2_err", 32'(errCount), 32'd1);

    // SEND to addr1, one strobe then silence until timeout.
    startTxn(2'b10, 1'b1, 1'b0, 5);
    wordStrobe = 1'b1; step();
    repeat (7) step();
    check("t3_noEarlyRb", 32'(smRollback), 32'h0);
    check("t3_busy", 32'(busy), 32'd1);
    step();
    check("t3_smRollback", 32'(smRollback), 32'h2);
    step();
    check("t3_status", 32'(lastStatus), 32'h3);

    // frameError beats a matching frameEnd.
    startTxn(2'b01, 1'b1, 1'b0, 1);
    wordStrobe = 1'b1; step();
    frameError = 1'b1; frameEnd = 1'b1; step();
    check("t4_rollback", 32'(smRollback), 32'h1);
    check("t4_noCommit", 32'(smCommit), 32'h0);
    step();
    check("t4_status", 32'(lastStatus), 32'h2);
    startTxn(2'b11, 1'b1, 1'b0, 1);
    check("t4_badHitPulses", 32'(pulses()), 32'h0);
    check("t4_badHitBusy", 32'(busy), 32'd0);
    step();
    check("t4_statusKept", 32'(lastStatus), 32'h2);

    // Zero-length SEND commits.
    startTxn(2'b01, 1'b1, 1'b0, 0);
    step(); step();
    frameEnd = 1'b1; step();
    check("t5_commit", 32'(smCommit), 32'h1);
    step();

    // Word counter overflow (16 strobes on a 4-bit counter).
    startTxn(2'b01, 1'b1, 1'b0, 3);
    repeat (16) begin wordStrobe = 1'b1; step(); end
    check("t6_ovfRollback", 32'(smRollback), 32'h1);
    step();
    check("t6_status", 32'(lastStatus), 32'h2);

    // Saturation of the rollback counter.
    repeat (300) begin
      startTxn(2'b10, 1'b0, 1'b1, 1);
      frameError = 1'b1; step();
      step();
    end
    check("t7_errSat", 32'(errCount), 32'd255);

    // Asynchronous reset in the middle of a transaction.
    startTxn(2'b01, 1'b1, 1'b0, 2);
    wordStrobe = 1'b1; step();
    #3 nRst = 1'b0;
    #1;
    check("t8_rstPulses", 32'(pulses()), 32'h0);
    check("t8_rstBusy", 32'(busy), 32'd0);
    check("t8_rstErr", 32'(errCount), 32'd0);
    check("t8_rstStatus", 32'(lastStatus), 32'd0);
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;
    step();
    startTxn(2'b01, 1'b1, 1'b0, 1);
    wordStrobe = 1'b1; frameEnd = 1'b1; step();
    check("t8_commitAfter", 32'(smCommit), 32'h1);
    step();
    check("t8_statusAfter", 32'(lastStatus), 32'h1);

    // Randomized traffic, alternating busy and sparse strobe phases.
    for (int i = 0; i < 3000; i++) begin
      frameStart    = ($urandom_range(0, 9) == 0);
      addrHit       = 2'($urandom_range(0, 3));
      cmdSend       = 1'($urandom_range(0, 1));
      cmdRecv       = 1'($urandom_range(0, 1));
      expectedWords = CW'($urandom_range(0, 4));
      frameEnd      = ($urandom_range(0, 5) == 0);
      frameError    = ($urandom_range(0, 39) == 0);
      if ((i / 500) % 2 == 0) wordStrobe = ($urandom_range(0, 2) != 0);
      else                    wordStrobe = ($urandom_range(0, 5) == 0);
      step();
    end

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_ring_txn_sequencer.md
Name: spi_ring_txn_sequencer

Overview:
- Sequences ring-buffer transactions (open/commit/rollback) for the SPI side of the dual-channel MIL-STD/SPI bridge.
- Sits between the SPI link's decoded frame events and the four ring-buffer control ports: SPI->MIL0, SPI->MIL1, MIL0->SPI, MIL1->SPI.
- SEND_DATA frames are written into the SPI->MIL buffer as a transaction. RECEIVE_DATA frames are read from the MIL->SPI buffer as a transaction.
- Each transaction is committed only when the frame completes with the announced word count. Otherwise it is rolled back.

Parameters:
- TIMEOUT_CYCLES, 65535: cycles without wordStrobe in an open transaction before forced rollback (1..65535).
- CNT_W, 16: width of the word counter and expectedWords.

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- frameStart  in  1  one-cycle pulse; SPI header decoded, addrHit/cmd inputs valid this cycle
- frameEnd  in  1  one-cycle pulse; SPI frame closed normally
- frameError  in  1  one-cycle pulse; SPI framing/CRC error
- addrHit  in  2  bit0 = block address 0 matched, bit1 = block address 1 matched
- cmdSend  in  1  command is SEND_DATA
- cmdRecv  in  1  command is RECEIVE_DATA
- expectedWords  in  CNT_W  data size from header, sampled on frameStart
- wordStrobe  in  1  one data word pushed/popped this cycle
- smOpen, smCommit, smRollback  out  2 each  SPI->MIL buffer control; bit index = channel
- msOpen, msCommit, msRollback  out  2 each  MIL->SPI buffer control; bit index = channel
- busy  out  1  transaction in progress
- lastStatus  out  2  00 none, 01 committed, 10 rolled back on error/mismatch, 11 rolled back on timeout
- errCount  out  8  saturating count of rollbacks

Behaviour:
- All outputs are registered.
- Reset (nRst low, asynchronous): state IDLE; all control pulses 0; busy 0; lastStatus 00; errCount 0; counters 0.
- Reset mid-transaction drops it silently; no rollback pulse is issued.
- States: IDLE, OPEN, ACTIVE, COMMIT, ROLLBACK.
- IDLE:
  - Leaves IDLE only on frameStart with a valid command.
  - Valid command: addrHit exactly one-hot, and exactly one of cmdSend/cmdRecv is set.
  - On a valid command, latch channel = index of addrHit, dir = cmdSend ? SM : MS, expected = expectedWords; clear wordCnt and the timeout counter; go to OPEN.
  - Invalid or other commands (RESET, RECEIVE_STS) are ignored: no pulses, no status change.
- OPEN (exactly 1 cycle): the open bit for the latched dir/channel is high for this cycle only. Next state is ACTIVE.
  - Latency: frameStart at cycle N gives open at N+1 and ACTIVE at N+2.
- OPEN and ACTIVE (common rules):
  - busy = 1.
  - wordStrobe increments wordCnt.
  - If wordCnt is already all-ones when another wordStrobe arrives, this is overflow: go to ROLLBACK with reason error.
  - Timeout counter clears on wordStrobe and otherwise increments. When it reaches TIMEOUT_CYCLES, go to ROLLBACK with reason timeout.
  - Event priority, highest first: frameError, frameStart (new frame while busy = abort; the new frame is dropped), overflow, frameEnd, timeout.
  - On frameEnd, compare (wordCnt + wordStrobe in the same cycle) against expected: equal goes to COMMIT, unequal goes to ROLLBACK with reason error.
  - expected = 0 with no strobes commits.
- COMMIT (1 cycle): commit bit for dir/channel high; lastStatus <= 01; next state IDLE; busy still 1 this cycle.
- ROLLBACK (1 cycle): rollback bit for dir/channel high; lastStatus <= 10 or 11 by reason; errCount += 1, saturating at 255; next state IDLE; busy 1.
- A frameStart arriving in COMMIT or ROLLBACK is ignored.
- Pulse constraints:
  - At most one of the 12 control bits is high in any cycle.
  - Open/commit/rollback never target a dir/channel other than the latched one.

Test Plan:
- SEND to addr0 (addrHit=01, cmdSend=1, expectedWords=3); 3 wordStrobes; frameEnd -> smOpen=01 at N+1; smCommit=01 one cycle after frameEnd; lastStatus=01; errCount=0.
- RECEIVE to addr1 (addrHit=10, expectedWords=2); 1 strobe; frameEnd -> msOpen=10, then msRollback=10; lastStatus=10; errCount=1.
- SEND to addr1 with TIMEOUT_CYCLES=8; 1 strobe then silence -> smRollback=10 exactly 8 cycles after the last strobe plus 1; lastStatus=11.
- frameError and frameEnd in the same cycle (count matches) -> rollback, not commit; lastStatus=10. Then frameStart with addrHit=11 -> ignored, no pulses, busy=0.
- expectedWords=0 SEND, frameEnd 2 cycles after OPEN -> smCommit. Separately, 300 forced rollbacks -> errCount=255.
- nRst asserted asynchronously mid-ACTIVE -> all outputs 0 immediately, no rollback pulse. After release, a new SEND completes normally.
